// File: rtl/mcpu_defs.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: FSM states, opcodes,
// ALU operations, PC sources, register destinations and the decoded instruction-class record.
package mcpu_defs;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_XORI  = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b100110;
    localparam logic [5:0] OP_SLT   = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_XOR  = 3'b111;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [1:0] RD_31 = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    typedef struct packed {
        logic       alu;
        logic       imm;
        logic       zext;
        logic       sll;
        logic       ls;
        logic       lw;
        logic       sw;
        logic       br;
        logic       beq;
        logic       bne;
        logic       bltz;
        logic       jmp;
        logic       j;
        logic       jr;
        logic       jal;
        logic       halt;
        logic [2:0] aluop;
    } dec_t;

endpackage

// File: rtl/mcpu_decode.sv
// Opcode to instruction-class flags; purely combinational, consumed by the control FSM.
module mcpu_decode
    import mcpu_defs::*;
#(
    parameter int              OP_W    = 6,
    parameter logic [OP_W-1:0] HALT_OP = 6'b111111
) (
    input  logic [OP_W-1:0] opcode,
    output dec_t            dec
);

    always_comb begin
        dec = '0;
        case (opcode)
            OP_ADD:   begin dec.alu = 1'b1; dec.aluop = ALU_ADD; end
            OP_SUB:   begin dec.alu = 1'b1; dec.aluop = ALU_SUB; end
            OP_ADDIU: begin dec.alu = 1'b1; dec.imm = 1'b1; dec.aluop = ALU_ADD; end
            OP_AND:   begin dec.alu = 1'b1; dec.aluop = ALU_AND; end
            OP_ANDI:  begin dec.alu = 1'b1; dec.imm = 1'b1; dec.zext = 1'b1; dec.aluop = ALU_AND; end
            OP_ORI:   begin dec.alu = 1'b1; dec.imm = 1'b1; dec.zext = 1'b1; dec.aluop = ALU_OR; end
            OP_XORI:  begin dec.alu = 1'b1; dec.imm = 1'b1; dec.zext = 1'b1; dec.aluop = ALU_XOR; end
            OP_SLL:   begin dec.alu = 1'b1; dec.sll = 1'b1; dec.aluop = ALU_SLL; end
            OP_SLTI:  begin dec.alu = 1'b1; dec.imm = 1'b1; dec.aluop = ALU_SLT; end
            OP_SLT:   begin dec.alu = 1'b1; dec.aluop = ALU_SLT; end
            OP_SW:    begin dec.ls = 1'b1; dec.sw = 1'b1; end
            OP_LW:    begin dec.ls = 1'b1; dec.lw = 1'b1; end
            OP_BEQ:   begin dec.br = 1'b1; dec.beq = 1'b1; end
            OP_BNE:   begin dec.br = 1'b1; dec.bne = 1'b1; end
            OP_BLTZ:  begin dec.br = 1'b1; dec.bltz = 1'b1; end
            OP_J:     begin dec.jmp = 1'b1; dec.j = 1'b1; end
            OP_JR:    begin dec.jmp = 1'b1; dec.jr = 1'b1; end
            OP_JAL:   begin dec.jmp = 1'b1; dec.jal = 1'b1; end
            HALT_OP:  dec.halt = 1'b1;
            default:  dec = '0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control unit: State is the only register; every datapath control is
// decoded combinationally from State, opcode and the ALU zero/sign flags.
module multi_cycle_ctrl
    import mcpu_defs::*;
#(
    parameter int              OP_W    = 6,
    parameter logic [OP_W-1:0] HALT_OP = 6'b111111
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            sign,
    output logic [2:0]      State,
    output logic            PCWre,
    output logic            IRWre,
    output logic            InsMemRW,
    output logic            RegWre,
    output logic [1:0]      RegDst,
    output logic            WrRegDSrc,
    output logic            ALUSrcA,
    output logic            ALUSrcB,
    output logic [2:0]      ALUOp,
    output logic            ExtSel,
    output logic [1:0]      PCSrc,
    output logic            mRD,
    output logic            mWR,
    output logic            DBDataSrc
);

    state_t state, state_nx;
    dec_t   dec;
    logic   taken;

    mcpu_decode #(.OP_W(OP_W), .HALT_OP(HALT_OP)) u_decode (
        .opcode (opcode),
        .dec    (dec)
    );

    assign State = state;
    assign taken = (dec.beq & zero) | (dec.bne & ~zero) | (dec.bltz & sign);

    always_ff @(posedge CLK) begin
        if (Reset) state <= S_IF;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        RegWre    = 1'b0;
        RegDst    = RD_31;
        WrRegDSrc = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = ALU_ADD;
        ExtSel    = 1'b0;
        PCSrc     = PC_SEQ;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        // Reset presents fetch-phase controls so no write strobe or PC load escapes.
        if (Reset) begin
            state_nx = S_IF;
            IRWre    = 1'b1;
            InsMemRW = 1'b1;
        end else begin
            case (state)
                S_IF: begin
                    IRWre    = 1'b1;
                    InsMemRW = 1'b1;
                    state_nx = S_ID;
                end
                S_ID: begin
                    if (dec.halt)     state_nx = S_ID;
                    else if (dec.alu) state_nx = S_EXE_AL;
                    else if (dec.br)  state_nx = S_EXE_BR;
                    else if (dec.ls)  state_nx = S_EXE_LS;
                    else begin
                        // Jumps and undefined opcodes complete here.
                        state_nx = S_IF;
                        PCWre    = 1'b1;
                        if (dec.jr)                PCSrc = PC_RS;
                        else if (dec.j | dec.jal)  PCSrc = PC_JUMP;
                        if (dec.jal) begin
                            RegWre    = 1'b1;
                            RegDst    = RD_31;
                            WrRegDSrc = 1'b0;
                        end
                    end
                end
                S_EXE_AL, S_WB_AL: begin
                    ALUSrcA = dec.sll;
                    ALUSrcB = dec.imm;
                    ExtSel  = ~dec.zext;
                    ALUOp   = dec.aluop;
                    if (state == S_WB_AL) begin
                        RegWre    = 1'b1;
                        WrRegDSrc = 1'b1;
                        RegDst    = dec.imm ? RD_RT : RD_RD;
                        PCWre     = 1'b1;
                        state_nx  = S_IF;
                    end else begin
                        state_nx  = S_WB_AL;
                    end
                end
                S_EXE_BR: begin
                    ALUOp    = ALU_SUB;
                    ExtSel   = 1'b1;
                    PCWre    = 1'b1;
                    PCSrc    = taken ? PC_BRANCH : PC_SEQ;
                    state_nx = S_IF;
                end
                S_EXE_LS: begin
                    ALUOp    = ALU_ADD;
                    ALUSrcB  = 1'b1;
                    ExtSel   = 1'b1;
                    state_nx = S_MEM;
                end
                S_MEM: begin
                    if (dec.sw) begin
                        mWR      = 1'b1;
                        PCWre    = 1'b1;
                        state_nx = S_IF;
                    end else begin
                        mRD      = 1'b1;
                        state_nx = S_WB_LD;
                    end
                end
                S_WB_LD: begin
                    mRD       = 1'b1;
                    DBDataSrc = 1'b1;
                    RegWre    = 1'b1;
                    RegDst    = RD_RT;
                    WrRegDSrc = 1'b1;
                    PCWre     = 1'b1;
                    state_nx  = S_IF;
                end
                default: state_nx = S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: the driver pushes the hand-computed control word for
// each cycle into a queue; the monitor pops and compares on the falling edge.
module tb_multi_cycle_ctrl;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] opcode;
    logic       zero, sign;
    logic [2:0] State;
    logic       PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel;
    logic       mRD, mWR, DBDataSrc;
    logic [1:0] RegDst, PCSrc;
    logic [2:0] ALUOp;

    int errors = 0;
    int checks = 0;

    logic [20:0] exp_q[$];
    string       name_q[$];

    multi_cycle_ctrl dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .sign(sign),
        .State(State), .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
        .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel), .PCSrc(PCSrc),
        .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc)
    );

    always #5 CLK = ~CLK;

    // Control word layout:
    // State PCWre IRWre InsMemRW RegWre RegDst WrRegDSrc ALUSrcA ALUSrcB ALUOp ExtSel PCSrc mRD mWR DBDataSrc
    function automatic logic [20:0] cw(input logic [2:0] st, input logic pcw, input logic irw,
                                       input logic imr, input logic rgw, input logic [1:0] rdst,
                                       input logic wrs, input logic sa, input logic sb,
                                       input logic [2:0] aop, input logic ext, input logic [1:0] pcs,
                                       input logic rd, input logic wr, input logic dbs);
        return {st, pcw, irw, imr, rgw, rdst, wrs, sa, sb, aop, ext, pcs, rd, wr, dbs};
    endfunction

    wire [20:0] act = {State, PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc, ALUSrcA,
                       ALUSrcB, ALUOp, ExtSel, PCSrc, mRD, mWR, DBDataSrc};

    // Fetch-phase word (also what Reset presents) and a bare decode word.
    logic [20:0] w_if, w_id;

    task automatic drive(input logic rst, input logic [5:0] op, input logic z, input logic s);
        Reset  = rst;
        opcode = op;
        zero   = z;
        sign   = s;
    endtask

    task automatic expect_cycle(input logic [20:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            logic [20:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks = checks + 1;
            if (act !== e) begin
                errors = errors + 1;
                $display("FAIL %s: got %b required %b (time %0t)", nm, act, e, $time);
            end
        end
    end

    initial begin
        w_if = cw(3'b000, 0, 1, 1, 0, 2'b00, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0);
        w_id = cw(3'b001, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0);

        // Reset for 2 cycles; the first cycle's state is unknown so only the second is checked.
        drive(1, 6'b000000, 0, 0);
        @(posedge CLK); #1;
        expect_cycle(w_if, "reset");

        // add
        drive(0, 6'b000000, 0, 0);
        expect_cycle(w_if, "add_if");
        expect_cycle(w_id, "add_id");
        expect_cycle(cw(3'b110, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000, 1, 2'b00, 0, 0, 0), "add_exe");
        expect_cycle(cw(3'b111, 1, 0, 0, 1, 2'b10, 1, 0, 0, 3'b000, 1, 2'b00, 0, 0, 0), "add_wb");

        // ori: immediate, zero-extended
        drive(0, 6'b010010, 0, 0);
        expect_cycle(w_if, "ori_if");
        expect_cycle(w_id, "ori_id");
        expect_cycle(cw(3'b110, 0, 0, 0, 0, 2'b00, 0, 0, 1, 3'b011, 0, 2'b00, 0, 0, 0), "ori_exe");
        expect_cycle(cw(3'b111, 1, 0, 0, 1, 2'b01, 1, 0, 1, 3'b011, 0, 2'b00, 0, 0, 0), "ori_wb");

        // sll: shift amount on A
        drive(0, 6'b011000, 0, 0);
        expect_cycle(w_if, "sll_if");
        expect_cycle(w_id, "sll_id");
        expect_cycle(cw(3'b110, 0, 0, 0, 0, 2'b00, 0, 1, 0, 3'b010, 1, 2'b00, 0, 0, 0), "sll_exe");
        expect_cycle(cw(3'b111, 1, 0, 0, 1, 2'b10, 1, 1, 0, 3'b010, 1, 2'b00, 0, 0, 0), "sll_wb");

        // lw
        drive(0, 6'b110001, 0, 0);
        expect_cycle(w_if, "lw_if");
        expect_cycle(w_id, "lw_id");
        expect_cycle(cw(3'b010, 0, 0, 0, 0, 2'b00, 0, 0, 1, 3'b000, 1, 2'b00, 0, 0, 0), "lw_exe");
        expect_cycle(cw(3'b011, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 2'b00, 1, 0, 0), "lw_mem");
        expect_cycle(cw(3'b100, 1, 0, 0, 1, 2'b01, 1, 0, 0, 3'b000, 0, 2'b00, 1, 0, 1), "lw_wb");

        // beq taken / not taken, bltz taken
        drive(0, 6'b110100, 1, 0);
        expect_cycle(w_if, "beq_t_if");
        expect_cycle(w_id, "beq_t_id");
        expect_cycle(cw(3'b101, 1, 0, 0, 0, 2'b00, 0, 0, 0, 3'b001, 1, 2'b01, 0, 0, 0), "beq_taken");
        drive(0, 6'b110100, 0, 0);
        expect_cycle(w_if, "beq_n_if");
        expect_cycle(w_id, "beq_n_id");
        expect_cycle(cw(3'b101, 1, 0, 0, 0, 2'b00, 0, 0, 0, 3'b001, 1, 2'b00, 0, 0, 0), "beq_not_taken");
        drive(0, 6'b110110, 0, 1);
        expect_cycle(w_if, "bltz_if");
        expect_cycle(w_id, "bltz_id");
        expect_cycle(cw(3'b101, 1, 0, 0, 0, 2'b00, 0, 0, 0, 3'b001, 1, 2'b01, 0, 0, 0), "bltz_taken");

        // jal, jr, undefined opcode
        drive(0, 6'b111010, 0, 0);
        expect_cycle(w_if, "jal_if");
        expect_cycle(cw(3'b001, 1, 0, 0, 1, 2'b00, 0, 0, 0, 3'b000, 0, 2'b11, 0, 0, 0), "jal_id");
        drive(0, 6'b111001, 0, 0);
        expect_cycle(w_if, "jr_if");
        expect_cycle(cw(3'b001, 1, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 2'b10, 0, 0, 0), "jr_id");
        drive(0, 6'b000011, 0, 0);
        expect_cycle(w_if, "undef_if");
        expect_cycle(cw(3'b001, 1, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0), "undef_id");

        // sw with Reset in sMEM: fetch-phase controls, no write, no PC load
        drive(0, 6'b110000, 0, 0);
        expect_cycle(w_if, "sw_if");
        expect_cycle(w_id, "sw_id");
        expect_cycle(cw(3'b010, 0, 0, 0, 0, 2'b00, 0, 0, 1, 3'b000, 1, 2'b00, 0, 0, 0), "sw_exe");
        drive(1, 6'b110000, 0, 0);
        expect_cycle(cw(3'b011, 0, 1, 1, 0, 2'b00, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0), "sw_mem_reset");
        drive(0, 6'b110000, 0, 0);
        expect_cycle(w_if, "sw_after_reset");

        // sw completing normally
        expect_cycle(w_id, "sw2_id");
        expect_cycle(cw(3'b010, 0, 0, 0, 0, 2'b00, 0, 0, 1, 3'b000, 1, 2'b00, 0, 0, 0), "sw2_exe");
        expect_cycle(cw(3'b011, 1, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 2'b00, 0, 1, 0), "sw2_mem");

        // halt parks in sID until Reset
        drive(0, 6'b111111, 0, 0);
        expect_cycle(w_if, "halt_if");
        for (int i = 0; i < 20; i++) expect_cycle(w_id, "halt_hold");
        drive(1, 6'b111111, 0, 0);
        expect_cycle(cw(3'b001, 0, 1, 1, 0, 2'b00, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0), "halt_reset");
        drive(0, 6'b000000, 0, 0);
        expect_cycle(w_if, "halt_released");

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d entries left required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
